tea_host_ctrl: RTL and testbench
================================

Name: tea_host_ctrl

Overview:
- Bus-initiator front end for the `tea` register-mapped cipher core. Converts a 64-bit valid/ready block stream into the core's register write / start / poll / read-back sequence, and returns results on an output stream.
- Caches the 128-bit key so key registers are rewritten only after a key update.
- Sits between the system datapath and one `tea` instance.

Parameters:
- WORD_SIZE, 32, core register width; only 32 is supported.
- START_TIMEOUT, 4, max cycles to wait for the core's o_ready to fall after the CTRL write.
- DONE_TIMEOUT, 64, max cycles to wait for the core's o_ready to rise again.

Ports:
- i_clk  in  1  clock; the block runs on one clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_key  in  128  key; k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
- i_key_valid  in  1  load i_key into the key cache; accepted only when o_key_ready=1.
- o_key_ready  out  1  high in IDLE.
- i_s_valid  in  1  input block valid.
- o_s_ready  out  1  input block ready; high in IDLE only.
- i_s_data  in  64  block; v0=[63:32], v1=[31:0].
- i_s_mode  in  1  0=encrypt, 1=decrypt.
- o_m_valid  out  1  result valid.
- i_m_ready  in  1  result ready.
- o_m_data  out  64  result; {reg7, reg8}.
- o_m_mode  out  1  mode of the block that produced the result.
- o_bus_addr  out  4  core i_addr.
- o_bus_wdata  out  32  core i_data.
- o_bus_we  out  1  core i_we.
- i_bus_rdata  in  32  core o_data; valid 1 cycle after the address is presented with we=0.
- i_bus_ready  in  1  core o_ready.
- o_busy  out  1  high in any state other than IDLE.
- o_err_timeout  out  1  sticky timeout flag; cleared only by i_err_clr or reset.
- i_err_clr  in  1  clear o_err_timeout.

Behaviour:
- Reset: all outputs 0. Key cache 0. key_dirty=1. State IDLE.
- Reset asserted mid-operation aborts immediately. The core is reset by its own reset; this block does not issue CTRL_NONE.
- Key handling:
  - i_key_valid && o_key_ready: capture i_key, set key_dirty.
  - If i_key_valid and s-handshake occur in the same cycle, the new key applies to that block.
- Bus rule: o_bus_we is high only in write states. Otherwise o_bus_we=0 and o_bus_addr holds the last read address (default 7).
- States:
  - IDLE: o_s_ready=1. On handshake, latch data and mode, then go to WKEY0 if key_dirty, else WDAT0.
  - WKEY0..3: write addr 2..5 with k0..k3. key_dirty cleared on WKEY3.
  - WDAT0/WDAT1: write addr 0 = v0, then addr 1 = v1.
  - WCTRL: write addr 6 = CTRL_ENC or CTRL_DEC; reset the timer.
  - WBUSY: wait for i_bus_ready=0 → WDONE. At START_TIMEOUT → ERR.
  - WDONE: wait for i_bus_ready=1 → RD0. At DONE_TIMEOUT → ERR.
  - RD0: addr 7, we=0.
  - RD1: addr 8; capture i_bus_rdata into result[63:32].
  - RD2: capture i_bus_rdata into result[31:0] → OUT.
  - OUT: o_m_valid=1; data and mode held stable until i_m_ready; then → IDLE.
  - ERR: write addr 6 = CTRL_NONE for one cycle, set o_err_timeout, drop the block, → IDLE. No o_m_valid is produced.
- Latency, handshake to o_m_valid, ideal core:
  - Key clean: 3 writes + 2 (busy detect) + 33 (core rounds) + 3 reads ≈ 41 cycles.
  - Key dirty: +4 cycles.
- Throughput: one block in flight; no input is accepted until OUT completes.
- Timer: 7-bit saturating counter, reset on each state entry.
- i_err_clr and a timeout in the same cycle: set wins.

Decomposition:
- Shared package `tea_pkg`:
  - CTRL_NONE=0, CTRL_ENC=1, CTRL_DEC=2.
  - Register address constants ADDR_V0..ADDR_R1 (0..8).
  - State enum.
  - DELTA.
- No sub-module: the FSM, key cache and timer live in one file, roughly 200 lines.
- Bench instantiates `tea` as the DUT's slave, with an inverter on reset.

Test Plan:
- Key 0, plaintext 0, encrypt → o_m_data=0x41EA3A0A94BAA940. Writes observed in the order addr 2,3,4,5,0,1,6.
- Feed that result back with mode=1, same key → o_m_data=0. Only addr 0, 1, 6 written (key cache clean).
- Key update mid-stream: block A with key X, i_key_valid with key Y, block B → key registers rewritten only before B. B result matches the software model for key Y.
- Stub core that never drops i_bus_ready → after 4 cycles in WBUSY, CTRL_NONE written to addr 6 and o_err_timeout=1, with no o_m_valid. i_err_clr → flag cleared.
- Backpressure: i_m_ready=0 for 10 cycles → o_m_valid, o_m_data and o_m_mode stable; o_s_ready=0 throughout.
- i_rst pulsed during WDONE → all outputs 0 asynchronously. After release, next block yields the correct ciphertext, with key registers rewritten.

Source files
------------

// File: rtl/tea_pkg.sv
// -----------------------------------------------------------------------------
// tea_pkg
// Shared constants and types for the tea cipher core and its host controller.
//   CTRL_*  : values written to the core's control register (address 6)
//   ADDR_*  : core register map (0..8)
//   DELTA   : TEA key-schedule constant
//   state_e : host controller FSM state encoding
// -----------------------------------------------------------------------------
package tea_pkg;

  localparam logic [31:0] CTRL_NONE = 32'd0;
  localparam logic [31:0] CTRL_ENC  = 32'd1;
  localparam logic [31:0] CTRL_DEC  = 32'd2;

  localparam logic [3:0] ADDR_V0   = 4'd0;
  localparam logic [3:0] ADDR_V1   = 4'd1;
  localparam logic [3:0] ADDR_K0   = 4'd2;
  localparam logic [3:0] ADDR_K1   = 4'd3;
  localparam logic [3:0] ADDR_K2   = 4'd4;
  localparam logic [3:0] ADDR_K3   = 4'd5;
  localparam logic [3:0] ADDR_CTRL = 4'd6;
  localparam logic [3:0] ADDR_R0   = 4'd7;
  localparam logic [3:0] ADDR_R1   = 4'd8;

  localparam logic [31:0] DELTA = 32'h9E37_79B9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WKEY0,
    ST_WKEY1,
    ST_WKEY2,
    ST_WKEY3,
    ST_WDAT0,
    ST_WDAT1,
    ST_WCTRL,
    ST_WBUSY,
    ST_WDONE,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_OUT,
    ST_ERR
  } state_e;

endpackage

// File: rtl/tea_host_ctrl.sv
// -----------------------------------------------------------------------------
// tea_host_ctrl
// Bus-initiator front end for one register-mapped tea cipher core. Accepts a
// 64-bit block on a valid/ready stream, writes key (only when the cached key
// changed), data and control registers, waits for the core to go busy and
// come back, reads the two result words and presents them on an output stream.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_key / i_key_valid     key load, accepted when o_key_ready (IDLE only)
//   i_s_*  / o_s_ready      input block stream (data {v0,v1}, mode 0=enc 1=dec)
//   o_m_*  / i_m_ready      result stream ({reg7,reg8}, mode of the block)
//   o_bus_*, i_bus_*        core register port (addr, wdata, we, rdata, ready)
//   o_busy                  any state other than IDLE
//   o_err_timeout/i_err_clr sticky core-timeout flag and its clear
// -----------------------------------------------------------------------------
module tea_host_ctrl
  import tea_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int START_TIMEOUT = 4,
  parameter int DONE_TIMEOUT  = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [127:0]         i_key,
  input  logic                 i_key_valid,
  output logic                 o_key_ready,
  input  logic                 i_s_valid,
  output logic                 o_s_ready,
  input  logic [63:0]          i_s_data,
  input  logic                 i_s_mode,
  output logic                 o_m_valid,
  input  logic                 i_m_ready,
  output logic [63:0]          o_m_data,
  output logic                 o_m_mode,
  output logic [3:0]           o_bus_addr,
  output logic [WORD_SIZE-1:0] o_bus_wdata,
  output logic                 o_bus_we,
  input  logic [WORD_SIZE-1:0] i_bus_rdata,
  input  logic                 i_bus_ready,
  output logic                 o_busy,
  output logic                 o_err_timeout,
  input  logic                 i_err_clr
);

  localparam logic [6:0] START_LIM = 7'(START_TIMEOUT - 1);
  localparam logic [6:0] DONE_LIM  = 7'(DONE_TIMEOUT - 1);
  localparam logic [6:0] TMR_MAX   = 7'h7F;

  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic           dirty_q, dirty_d;
  logic [63:0]    blk_q, blk_d;
  logic           mode_q, mode_d;
  logic [63:0]    res_q, res_d;
  logic [3:0]     rd_addr_q, rd_addr_d;
  logic [6:0]     timer_q, timer_d;
  logic           err_q, err_d;

  // Registered outputs, derived from the next state so they line up with state_q.
  logic           s_ready_q, s_ready_d;
  logic           key_ready_q, key_ready_d;
  logic           m_valid_q, m_valid_d;
  logic           busy_q, busy_d;
  logic           we_q, we_d;
  logic [3:0]     addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;

  logic           s_hs;
  logic           k_hs;

  assign s_hs = i_s_valid && s_ready_q;
  assign k_hs = i_key_valid && key_ready_q;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    dirty_d   = dirty_q;
    blk_d     = blk_q;
    mode_d    = mode_q;
    res_d     = res_q;
    rd_addr_d = rd_addr_q;
    err_d     = err_q;

    if (k_hs) begin
      key_d   = i_key;
      dirty_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_hs) begin
          blk_d   = i_s_data;
          mode_d  = i_s_mode;
          // A key accepted in the same cycle applies to this block.
          state_d = (dirty_q || k_hs) ? ST_WKEY0 : ST_WDAT0;
        end
      end
      ST_WKEY0: state_d = ST_WKEY1;
      ST_WKEY1: state_d = ST_WKEY2;
      ST_WKEY2: state_d = ST_WKEY3;
      ST_WKEY3: begin
        dirty_d = 1'b0;
        state_d = ST_WDAT0;
      end
      ST_WDAT0: state_d = ST_WDAT1;
      ST_WDAT1: state_d = ST_WCTRL;
      ST_WCTRL: state_d = ST_WBUSY;
      ST_WBUSY: begin
        if (!i_bus_ready)            state_d = ST_WDONE;
        else if (timer_q >= START_LIM) state_d = ST_ERR;
      end
      ST_WDONE: begin
        if (i_bus_ready)             state_d = ST_RD0;
        else if (timer_q >= DONE_LIM)  state_d = ST_ERR;
      end
      ST_RD0: state_d = ST_RD1;
      // Read data lags the presented address by one cycle.
      ST_RD1: begin
        res_d[63:32] = i_bus_rdata[31:0];
        state_d      = ST_RD2;
      end
      ST_RD2: begin
        res_d[31:0] = i_bus_rdata[31:0];
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (i_m_ready) state_d = ST_IDLE;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Timer restarts on every state change and saturates otherwise.
    if (state_d != state_q)   timer_d = '0;
    else if (timer_q == TMR_MAX) timer_d = timer_q;
    else                      timer_d = timer_q + 7'd1;

    // Setting the flag wins over a simultaneous clear.
    if (i_err_clr)          err_d = 1'b0;
    if (state_d == ST_ERR)  err_d = 1'b1;

    if (state_d == ST_RD0) rd_addr_d = ADDR_R0;
    if (state_d == ST_RD1) rd_addr_d = ADDR_R1;

    we_d    = 1'b0;
    addr_d  = rd_addr_d;
    wdata_d = '0;
    case (state_d)
      ST_WKEY0: begin we_d = 1'b1; addr_d = ADDR_K0;   wdata_d = key_d[127:96]; end
      ST_WKEY1: begin we_d = 1'b1; addr_d = ADDR_K1;   wdata_d = key_d[95:64];  end
      ST_WKEY2: begin we_d = 1'b1; addr_d = ADDR_K2;   wdata_d = key_d[63:32];  end
      ST_WKEY3: begin we_d = 1'b1; addr_d = ADDR_K3;   wdata_d = key_d[31:0];   end
      ST_WDAT0: begin we_d = 1'b1; addr_d = ADDR_V0;   wdata_d = blk_d[63:32];  end
      ST_WDAT1: begin we_d = 1'b1; addr_d = ADDR_V1;   wdata_d = blk_d[31:0];   end
      ST_WCTRL: begin
        we_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = mode_d ? CTRL_DEC : CTRL_ENC;
      end
      ST_ERR:   begin we_d = 1'b1; addr_d = ADDR_CTRL; wdata_d = CTRL_NONE;     end
      default:  ;
    endcase

    s_ready_d   = (state_d == ST_IDLE);
    key_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    m_valid_d   = (state_d == ST_OUT);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      dirty_q     <= 1'b1;
      blk_q       <= '0;
      mode_q      <= 1'b0;
      res_q       <= '0;
      rd_addr_q   <= ADDR_R0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      s_ready_q   <= 1'b0;
      key_ready_q <= 1'b0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      dirty_q     <= dirty_d;
      blk_q       <= blk_d;
      mode_q      <= mode_d;
      res_q       <= res_d;
      rd_addr_q   <= rd_addr_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      s_ready_q   <= s_ready_d;
      key_ready_q <= key_ready_d;
      m_valid_q   <= m_valid_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign o_key_ready   = key_ready_q;
  assign o_s_ready     = s_ready_q;
  assign o_m_valid     = m_valid_q;
  assign o_m_data      = res_q;
  assign o_m_mode      = mode_q;
  assign o_bus_addr    = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign o_bus_we      = we_q;
  assign o_busy        = busy_q;
  assign o_err_timeout = err_q;

endmodule

// File: tb/tb_tea_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tea_host_ctrl
// Drives tea_host_ctrl against a behavioural register-mapped tea core (with an
// active-low reset fed by an inverter) and checks results, bus write order,
// key caching, backpressure, timeout handling and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_tea_host_ctrl;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [127:0] i_key = '0;
  logic         i_key_valid = 1'b0;
  logic         o_key_ready;
  logic         i_s_valid = 1'b0;
  logic         o_s_ready;
  logic [63:0]  i_s_data = '0;
  logic         i_s_mode = 1'b0;
  logic         o_m_valid;
  logic         i_m_ready = 1'b1;
  logic [63:0]  o_m_data;
  logic         o_m_mode;
  logic [3:0]   o_bus_addr;
  logic [31:0]  o_bus_wdata;
  logic         o_bus_we;
  logic [31:0]  i_bus_rdata;
  logic         i_bus_ready;
  logic         o_busy;
  logic         o_err_timeout;
  logic         i_err_clr = 1'b0;

  always #5 i_clk = ~i_clk;

  tea_host_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_key        (i_key),
    .i_key_valid  (i_key_valid),
    .o_key_ready  (o_key_ready),
    .i_s_valid    (i_s_valid),
    .o_s_ready    (o_s_ready),
    .i_s_data     (i_s_data),
    .i_s_mode     (i_s_mode),
    .o_m_valid    (o_m_valid),
    .i_m_ready    (i_m_ready),
    .o_m_data     (o_m_data),
    .o_m_mode     (o_m_mode),
    .o_bus_addr   (o_bus_addr),
    .o_bus_wdata  (o_bus_wdata),
    .o_bus_we     (o_bus_we),
    .i_bus_rdata  (i_bus_rdata),
    .i_bus_ready  (i_bus_ready),
    .o_busy       (o_busy),
    .o_err_timeout(o_err_timeout),
    .i_err_clr    (i_err_clr)
  );

  // ---------------- software TEA ----------------
  function automatic logic [63:0] tea_model(input logic dec, input logic [63:0] v,
                                            input logic [127:0] k);
    logic [31:0] v0, v1, s, k0, k1, k2, k3;
    v0 = v[63:32]; v1 = v[31:0];
    k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
    if (!dec) begin
      s = 32'd0;
      for (int r = 0; r < 32; r++) begin
        s  = s + 32'h9E3779B9;
        v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
        v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
      end
    end else begin
      s = 32'hC6EF3720;
      for (int r = 0; r < 32; r++) begin
        v1 = v1 - (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
        v0 = v0 - (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
        s  = s - 32'h9E3779B9;
      end
    end
    return {v0, v1};
  endfunction

  // ---------------- behavioural tea core ----------------
  logic        core_rst_n;
  logic [31:0] creg [0:8];
  logic        core_busy;
  logic        core_dec;
  int          core_cnt;
  logic        stub_stuck = 1'b0;   // core ignores CTRL starts and never goes busy

  assign core_rst_n = ~i_rst;

  always @(posedge i_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      for (int i = 0; i < 9; i++) creg[i] <= '0;
      core_busy   <= 1'b0;
      core_dec    <= 1'b0;
      core_cnt    <= 0;
      i_bus_ready <= 1'b1;
      i_bus_rdata <= '0;
    end else begin
      i_bus_rdata <= (o_bus_addr <= 4'd8) ? creg[o_bus_addr] : 32'd0;
      if (o_bus_we && o_bus_addr < 4'd6) creg[o_bus_addr] <= o_bus_wdata;
      if (core_busy) begin
        if (core_cnt == 0) begin
          {creg[7], creg[8]} <= tea_model(core_dec, {creg[0], creg[1]},
                                          {creg[2], creg[3], creg[4], creg[5]});
          core_busy   <= 1'b0;
          i_bus_ready <= 1'b1;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
      if (o_bus_we && o_bus_addr == 4'd6) begin
        if (o_bus_wdata == 32'd0) begin
          core_busy   <= 1'b0;
          i_bus_ready <= 1'b1;
        end else if (!stub_stuck) begin
          core_busy   <= 1'b1;
          core_dec    <= (o_bus_wdata == 32'd2);
          core_cnt    <= 32;
          i_bus_ready <= 1'b0;
        end
      end
    end
  end

  // ---------------- bus / stream monitor ----------------
  int          cyc = 0;
  int          wr_cnt = 0;
  int          mv_cnt = 0;
  logic [3:0]  wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];
  int          wr_cyc  [0:1023];

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_m_valid) mv_cnt <= mv_cnt + 1;
    if (o_bus_we && wr_cnt < 1024) begin
      wr_addr[wr_cnt] <= o_bus_addr;
      wr_data[wr_cnt] <= o_bus_wdata;
      wr_cyc[wr_cnt]  <= cyc;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [106:0] all_outs();
    return {o_key_ready, o_s_ready, o_m_valid, o_m_data, o_m_mode, o_bus_addr,
            o_bus_wdata, o_bus_we, o_busy, o_err_timeout};
  endfunction

  task automatic write_seq(input int s, output logic [31:0] seq, output int n);
    seq = '0;
    n   = wr_cnt - s;
    for (int i = s; i < wr_cnt; i++) seq = {seq[27:0], wr_addr[i]};
  endtask

  task automatic load_key(input logic [127:0] k);
    for (int i = 0; i < 100 && !o_key_ready; i++) @(negedge i_clk);
    check("key_ready_wait", o_key_ready, 1);
    i_key = k; i_key_valid = 1'b1;
    @(negedge i_clk);
    i_key_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] d, input logic m,
                            input logic with_key, input logic [127:0] k);
    for (int i = 0; i < 100 && !o_s_ready; i++) @(negedge i_clk);
    check("s_ready_wait", o_s_ready, 1);
    i_s_data = d; i_s_mode = m; i_s_valid = 1'b1;
    if (with_key) begin i_key = k; i_key_valid = 1'b1; end
    @(negedge i_clk);
    i_s_valid = 1'b0; i_key_valid = 1'b0;
  endtask

  task automatic get_result(output logic [63:0] d, output logic m);
    for (int i = 0; i < 200 && !o_m_valid; i++) @(negedge i_clk);
    check("m_valid_wait", o_m_valid, 1);
    d = o_m_data; m = o_m_mode;
    i_m_ready = 1'b1;
    @(negedge i_clk);
  endtask

  // Full transaction: returns result, mode, packed write-address order and count.
  task automatic run_block(input logic [63:0] d, input logic m, input logic with_key,
                           input logic [127:0] k, output logic [63:0] r, output logic rm,
                           output logic [31:0] seq, output int n);
    int s;
    s = wr_cnt;
    send_block(d, m, with_key, k);
    get_result(r, rm);
    write_seq(s, seq, n);
  endtask

  localparam logic [127:0] KEY_X = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] KEY_Y = 128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0;
  localparam logic [63:0]  CT0   = 64'h41EA_3A0A_94BA_A940;

  logic [63:0] r;
  logic        rm;
  logic [31:0] seq;
  int          n;
  int          s0, mv0, c_start, c_none;
  logic        stable;
  logic [63:0] held_d;
  logic        held_m;

  initial begin
    // ---- reset state ----
    #2;
    check("reset_outs", all_outs(), '0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_ready", {o_s_ready, o_key_ready, o_busy, o_bus_we, o_bus_addr}, {4'b1100, 4'd7});

    // ---- key 0, plaintext 0, encrypt: full key write ----
    run_block(64'd0, 1'b0, 1'b0, '0, r, rm, seq, n);
    check("enc0_data", r, CT0);
    check("enc0_mode", rm, 1'b0);
    check("enc0_wseq", seq, 32'h0234_5016);
    check("enc0_wcnt", n, 7);

    // ---- decrypt back with cached key ----
    run_block(CT0, 1'b1, 1'b0, '0, r, rm, seq, n);
    check("dec0_data", r, 64'd0);
    check("dec0_mode", rm, 1'b1);
    check("dec0_wseq", seq, 32'h0000_0016);

    // ---- key update mid-stream ----
    load_key(KEY_X);
    run_block(64'h0011_2233_4455_6677, 1'b0, 1'b0, '0, r, rm, seq, n);
    check("keyx_data", r, tea_model(1'b0, 64'h0011_2233_4455_6677, KEY_X));
    check("keyx_wcnt", n, 7);
    run_block(64'h8899_AABB_CCDD_EEFF, 1'b0, 1'b0, '0, r, rm, seq, n);
    check("keyx_clean_wcnt", n, 3);
    s0 = wr_cnt;
    run_block(64'hCAFE_BABE_1234_5678, 1'b0, 1'b1, KEY_Y, r, rm, seq, n);
    check("keyy_data", r, tea_model(1'b0, 64'hCAFE_BABE_1234_5678, KEY_Y));
    check("keyy_wseq", seq, 32'h0234_5016);
    check("keyy_k0", wr_data[s0], KEY_Y[127:96]);
    check("keyy_k3", wr_data[s0+3], KEY_Y[31:0]);
    run_block(64'h0F0F_F0F0_5A5A_A5A5, 1'b1, 1'b0, '0, r, rm, seq, n);
    check("keyy_dec_data", r, tea_model(1'b1, 64'h0F0F_F0F0_5A5A_A5A5, KEY_Y));
    check("keyy_dec_wcnt", n, 3);

    // ---- backpressure ----
    i_m_ready = 1'b0;
    send_block(64'h1111_2222_3333_4444, 1'b1, 1'b0, '0);
    for (int i = 0; i < 200 && !o_m_valid; i++) @(negedge i_clk);
    check("bp_valid", o_m_valid, 1'b1);
    held_d = o_m_data; held_m = o_m_mode;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (!o_m_valid || o_m_data !== held_d || o_m_mode !== held_m || o_s_ready)
        stable = 1'b0;
    end
    check("bp_stable", stable, 1'b1);
    check("bp_data", held_d, tea_model(1'b1, 64'h1111_2222_3333_4444, KEY_Y));
    check("bp_mode", held_m, 1'b1);
    i_m_ready = 1'b1;
    @(negedge i_clk);
    check("bp_release", {o_m_valid, o_s_ready}, 2'b01);

    // ---- start timeout with a stuck core ----
    stub_stuck = 1'b1;
    mv0 = mv_cnt;
    s0  = wr_cnt;
    send_block(64'h5555_6666_7777_8888, 1'b0, 1'b0, '0);
    for (int i = 0; i < 100 && !o_err_timeout; i++) @(negedge i_clk);
    check("to_flag", o_err_timeout, 1'b1);
    for (int i = 0; i < 20 && o_busy; i++) @(negedge i_clk);
    check("to_idle", o_busy, 1'b0);
    c_start = -1; c_none = -1;
    for (int i = s0; i < wr_cnt; i++) begin
      if (wr_addr[i] == 4'd6 && wr_data[i] != 0 && c_start < 0) c_start = wr_cyc[i];
      if (wr_addr[i] == 4'd6 && wr_data[i] == 0) c_none = wr_cyc[i];
    end
    check("to_last_wr", {wr_addr[wr_cnt-1], wr_data[wr_cnt-1]}, {4'd6, 32'd0});
    check("to_gap", c_none - c_start, 5);
    check("to_no_mvalid", mv_cnt - mv0, 0);
    repeat (3) @(negedge i_clk);
    check("to_sticky", o_err_timeout, 1'b1);
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    check("to_cleared", o_err_timeout, 1'b0);
    stub_stuck = 1'b0;

    // ---- asynchronous reset while waiting for the core ----
    send_block(64'h9999_AAAA_BBBB_CCCC, 1'b0, 1'b0, '0);
    repeat (8) @(negedge i_clk);
    check("rst_pre_busy", {o_busy, i_bus_ready}, 2'b10);
    #2 i_rst = 1'b1;
    #1 check("rst_async_outs", all_outs(), '0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_idle", {o_s_ready, o_busy}, 2'b10);
    run_block(64'd0, 1'b0, 1'b0, '0, r, rm, seq, n);
    check("rst_enc_data", r, CT0);
    check("rst_wseq", seq, 32'h0234_5016);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
